// File: rtl/jtgaiden_jumpprot.sv
// Protection-MCU emulator: CPU command bytes select an entry of a downloadable
// jump table, which is then read back MSB nibble first with a sequence tag.
module jtgaiden_jumpprot #(
  parameter int AW    = 5,   // must be > 4: the high index bits come from opcode 0x1
  parameter int DEPTH = 17,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_we,
  input  logic [7:0]    cpu_din,
  output logic [7:0]    cpu_dout,
  output logic          busy,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [DW-1:0] prog_data,
  output logic [DW-1:0] jump,
  output logic          jump_ok
);
  localparam int NIB = DW / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE, ST_GOTHI, ST_LOOKUP, ST_LATCH, ST_READY
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] index_q, index_d;
  logic [IW-1:0] ptr_q,   ptr_d;
  logic [7:0]    dout_q,  dout_d;
  logic [DW-1:0] jump_q,  jump_d;
  logic          ok_q,    ok_d;

  logic [DW-1:0]       mem [DEPTH];
  logic [DW-1:0]       rd_q;
  logic [3:0]          op, arg;
  logic                idx_ok, prog_ok, rd_en;
  logic [NIB-1:0][3:0] nibs;
  logic [IW-1:0]       nib_sel;

  assign op      = cpu_din[7:4];
  assign arg     = cpu_din[3:0];
  assign idx_ok  = {1'b0, index_q}   < DEPTH_W;
  assign prog_ok = {1'b0, prog_addr} < DEPTH_W;
  // Single RAM port: a download write wins and the lookup read retries next cycle.
  assign rd_en   = (state_q == ST_LOOKUP) && !prog_we && idx_ok;
  assign nibs    = jump_q;
  assign nib_sel = IW'(NIB-1) - ptr_q;

  // Table RAM is deliberately not reset so downloaded contents survive rst_n.
  always_ff @(posedge clk) begin
    if (prog_we && prog_ok) mem[prog_addr] <= prog_data;
    else if (rd_en)         rd_q <= mem[index_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      index_q <= '0;
      ptr_q   <= '0;
      dout_q  <= '0;
      jump_q  <= '0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      ptr_q   <= ptr_d;
      dout_q  <= dout_d;
      jump_q  <= jump_d;
      ok_q    <= ok_d;
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    ptr_d   = ptr_q;
    dout_d  = dout_q;
    jump_d  = jump_q;
    ok_d    = ok_q;
    case (state_q)
      ST_IDLE, ST_READY: begin
        if (cpu_we && op == 4'h1) begin
          index_d = AW'({arg, index_q[3:0]});
          ptr_d   = '0;
          state_d = ST_GOTHI;
        end else if (cpu_we && op == 4'h3 && state_q == ST_READY) begin
          dout_d = {4'(ptr_q) + 4'd1, nibs[nib_sel]};
          if (ptr_q == IW'(NIB-1)) begin
            ptr_d   = '0;
            state_d = ST_IDLE;
          end else begin
            ptr_d = ptr_q + IW'(1);
          end
        end
      end
      ST_GOTHI: begin
        if (cpu_we && op == 4'h2) begin
          index_d = {index_q[AW-1:4], arg};
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (!prog_we) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        jump_d  = idx_ok ? rd_q : '0;
        ok_d    = 1'b1;
        ptr_d   = '0;
        dout_d  = 8'h80;
        state_d = ST_READY;
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort overrides everything, including a lookup in flight.
    if (cpu_we && op == 4'h0) begin
      state_d = ST_IDLE;
      index_d = '0;
      ptr_d   = '0;
      dout_d  = '0;
      ok_d    = 1'b0;
    end
  end

  assign cpu_dout = dout_q;
  assign busy     = (state_q == ST_LOOKUP) || (state_q == ST_LATCH);
  assign jump     = jump_q;
  assign jump_ok  = ok_q;

endmodule

// File: doc/jtgaiden_jumpprot.md
Name: jtgaiden_jumpprot

Overview:
- Parametrised protection-MCU emulator for Gaiden-family boards (Wild Fang, Raiga and later sets).
- Receives command bytes from the main 68000 and returns entries of a jump-address table nibble by nibble.
- Table contents are loaded at download time through a prog port, so one RTL serves every game; sits between the CPU bus decoder and the protection read/write register.

Parameters:
- AW, 5, table index width; CPU-visible index is AW bits.
- DEPTH, 17, valid table entries; indices >= DEPTH return 0.
- DW, 16, jump entry width; must be a multiple of 4.
- NIB, DW/4, nibbles per entry (derived, not overridable).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- cpu_we  in  1  one-cycle write strobe to protection register
- cpu_din  in  8  command byte: [7:4] opcode, [3:0] argument
- cpu_dout  out  8  response byte: {sequence tag, data nibble}
- busy  out  1  high while a table lookup is pending
- prog_we  in  1  table write strobe (download)
- prog_addr  in  AW  table write address
- prog_data  in  DW  table write data
- jump  out  DW  last looked-up entry (debug/observability)
- jump_ok  out  1  high while jump holds a valid lookup result

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: cpu_dout=0, busy=0, jump=0, jump_ok=0, state=IDLE, index=0, ptr=0. Table RAM is not cleared; contents survive reset.
- Table: DEPTH x DW synchronous RAM, one-cycle read latency; written when prog_we=1 at prog_addr (prog_addr >= DEPTH ignored).
- Opcodes, accepted only on cpu_we=1:
  - 0x0: abort. Go to IDLE, index=0, ptr=0, cpu_dout=0, jump_ok=0. Legal from any state.
  - 0x1: load index high bits. index[AW-1:4] = argument (truncated to width); next state GOTHI. Ignored unless state is IDLE or READY.
  - 0x2: load index[3:0] = argument. Legal only in GOTHI; enters LOOKUP, busy=1.
  - 0x3: fetch nibble. Legal only in READY.
  - All other opcodes, and legal opcodes in the wrong state: no effect on state, index or cpu_dout.
- LOOKUP: issue RAM read. Result latched into jump next cycle; entry becomes 0 if index >= DEPTH. Then jump_ok=1, busy=0, ptr=0, state READY, cpu_dout=8'h80.
  - Total latency: 2 cycles from the 0x2 strobe to busy falling.
  - cpu_we during LOOKUP is ignored except opcode 0x0.
- READY, opcode 0x3: cpu_dout = {4'(ptr+1), jump nibble NIB-1-ptr} (MSB nibble first), then ptr increments.
  - After the NIB-th fetch: state IDLE, ptr=0. cpu_dout holds the last nibble until the next accepted command. jump and jump_ok stay unchanged until the next lookup or abort.
  - Further 0x3 writes in IDLE are ignored.
- Collision: prog_we and a LOOKUP read in the same cycle. The prog write takes the port; the lookup stalls one cycle (busy stays high) and then reads the updated data.
- rst_n asserted mid-lookup or mid-fetch: immediate return to reset values. No partial response remains after release.
- cpu_dout updates one cycle after the accepted strobe (registered).

Test Plan:
- Load table {0c0c,0cac,0d42,…,1b52} (17 entries). Writes 0x10, 0x22, then four 0x30 -> busy high 2 cycles; cpu_dout sequence 0x80, 0x10, 0x2D, 0x34, 0x42; jump=0x0D42; state IDLE after the 4th fetch.
- Index 16 (0x11, 0x20) -> jump=0x1B52. Index 20 (0x11, 0x24) -> jump=0x0000, jump_ok=1, nibbles 0x10, 0x20, 0x30, 0x40.
- Abort: write 0x00 after two fetches -> cpu_dout=0, jump_ok=0. A following 0x30 has no effect; a fresh lookup restarts at tag 1.
- Protocol errors: 0x22 without a prior 0x1, 0x30 in IDLE, opcode 0x7 -> cpu_dout, busy and state all unchanged.
- prog_we to index 5 in the same cycle as the lookup read of index 5 -> busy lasts 3 cycles; jump equals the newly written value.
- rst_n pulsed low during LOOKUP and during the 2nd fetch -> all outputs 0 asynchronously; after release, a lookup of index 0 returns 0x0C0C (table preserved).
